// File: rtl/con_bus_scheduler.sv
// con_bus_scheduler: arbiter and sequencer for the shared con_1/con_2/con_3 bus.
//
// The bus is shared by inbound operand words (testbench -> load unit) and outbound result
// words (output unit -> testbench). Only one requester owns the bus at a time. Every
// direction change is padded with TURNAROUND idle cycles. Grants are issued only while a
// layer is running.
//
// Ports:
//   clk, arst_n_in                   clock and asynchronous active-low reset
//   start, layer_done, running       layer-level handshake
//   in_req, in_ready, in_last        ingress requester (load unit)
//   in_grant, con_valid, con_ready   ingress grant and per-word handshake
//   out_req, out_data_*, out_*_in    egress requester (output unit) and its result word
//   out_ack                          result word taken this cycle
//   con_*_out, output_*              registered egress word and its coordinates
//   output_valid                     egress word on the bus this cycle
//   driving_cons                     bus direction: 0 = testbench drives, 1 = this block drives
module con_bus_scheduler #(
  parameter int unsigned IO_DATA_WIDTH      = 16,
  parameter int unsigned FEATURE_MAP_WIDTH  = 64,
  parameter int unsigned FEATURE_MAP_HEIGHT = 64,
  parameter int unsigned OUTPUT_NB_CHANNELS = 32,
  parameter int unsigned TURNAROUND         = 1,
  parameter int unsigned MAX_OUT_BURST      = 16,
  localparam int unsigned X_W  = $clog2(FEATURE_MAP_WIDTH),
  localparam int unsigned Y_W  = $clog2(FEATURE_MAP_HEIGHT),
  localparam int unsigned CH_W = $clog2(OUTPUT_NB_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  // Layer control
  input  logic                     start,
  input  logic                     layer_done,
  output logic                     running,
  // Ingress
  input  logic                     in_req,
  input  logic                     in_ready,
  input  logic                     in_last,
  output logic                     in_grant,
  input  logic                     con_valid,
  output logic                     con_ready,
  // Egress request side
  input  logic                     out_req,
  input  logic [IO_DATA_WIDTH-1:0] out_data_1,
  input  logic [IO_DATA_WIDTH-1:0] out_data_2,
  input  logic [IO_DATA_WIDTH-1:0] out_data_3,
  input  logic [X_W-1:0]           out_x_in,
  input  logic [Y_W-1:0]           out_y_in,
  input  logic [CH_W-1:0]          out_ch_in,
  output logic                     out_ack,
  // Egress bus side
  output logic [IO_DATA_WIDTH-1:0] con_1_out,
  output logic [IO_DATA_WIDTH-1:0] con_2_out,
  output logic [IO_DATA_WIDTH-1:0] con_3_out,
  output logic                     output_valid,
  output logic [X_W-1:0]           output_x,
  output logic [Y_W-1:0]           output_y,
  output logic [CH_W-1:0]          output_ch,
  output logic                     driving_cons
);

  localparam int unsigned CntW = $clog2(MAX_OUT_BURST + 1);
  localparam logic [CntW-1:0] BurstLast = CntW'(MAX_OUT_BURST - 1);
  localparam logic [2:0] TurnInit = 3'(TURNAROUND);

  typedef enum logic [1:0] {StIdle, StInBurst, StOutBurst, StTurn} state_e;

  state_e             state_q, state_d;
  logic               dir_q, dir_d;
  logic               last_out_q, last_out_d;
  logic               running_q, running_d;
  logic [2:0]         turn_cnt_q, turn_cnt_d;
  logic [CntW-1:0]    burst_cnt_q, burst_cnt_d;
  logic               go_out;

  logic                     valid_q;
  logic [IO_DATA_WIDTH-1:0] lane1_q, lane2_q, lane3_q;
  logic [X_W-1:0]           x_q;
  logic [Y_W-1:0]           y_q;
  logic [CH_W-1:0]          ch_q;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    last_out_d  = last_out_q;
    running_d   = running_q;
    turn_cnt_d  = turn_cnt_q;
    burst_cnt_d = burst_cnt_q;
    in_grant    = 1'b0;
    con_ready   = 1'b0;
    out_ack     = 1'b0;
    // Tie-break: egress wins only if the previous burst was ingress.
    go_out      = out_req && (!in_req || !last_out_q);

    if (!running_q && start) begin
      running_d = 1'b1;
    end else if (running_q && (state_q == StIdle) && layer_done) begin
      running_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // No new grant once the datapath reports the layer finished.
        if (running_q && !layer_done && (in_req || out_req)) begin
          burst_cnt_d = '0;
          if (go_out == dir_q) begin
            state_d = go_out ? StOutBurst : StInBurst;
          end else begin
            state_d    = StTurn;
            dir_d      = go_out;
            turn_cnt_d = TurnInit;
          end
        end
      end
      StTurn: begin
        // dir_q already points at the direction being turned towards.
        if (turn_cnt_q <= 3'd1) begin
          state_d = dir_q ? StOutBurst : StInBurst;
        end else begin
          turn_cnt_d = turn_cnt_q - 3'd1;
        end
      end
      StInBurst: begin
        in_grant  = 1'b1;
        con_ready = in_ready;
        if (con_valid && in_ready && in_last) begin
          state_d    = StIdle;
          last_out_d = 1'b0;
        end
      end
      StOutBurst: begin
        out_ack = out_req;
        if (!out_req) begin
          state_d    = StIdle;
          last_out_d = 1'b1;
        end else begin
          burst_cnt_d = burst_cnt_q + CntW'(1);
          if (burst_cnt_q == BurstLast) begin
            state_d    = StIdle;
            last_out_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      last_out_q  <= 1'b1;
      running_q   <= 1'b0;
      turn_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      last_out_q  <= last_out_d;
      running_q   <= running_d;
      turn_cnt_q  <= turn_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Egress word register: captured on ack, presented on the bus the following cycle,
  // and held afterwards.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      valid_q <= 1'b0;
      lane1_q <= '0;
      lane2_q <= '0;
      lane3_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ch_q    <= '0;
    end else begin
      valid_q <= out_ack;
      if (out_ack) begin
        lane1_q <= out_data_1;
        lane2_q <= out_data_2;
        lane3_q <= out_data_3;
        x_q     <= out_x_in;
        y_q     <= out_y_in;
        ch_q    <= out_ch_in;
      end
    end
  end

  assign running      = running_q;
  assign driving_cons = dir_q;
  assign output_valid = valid_q;
  assign con_1_out    = lane1_q;
  assign con_2_out    = lane2_q;
  assign con_3_out    = lane3_q;
  assign output_x     = x_q;
  assign output_y     = y_q;
  assign output_ch    = ch_q;

endmodule

// File: tb/tb_con_bus_scheduler.sv
module tb_con_bus_scheduler;

  localparam int unsigned IOW  = 16;
  localparam int unsigned XW   = 6;
  localparam int unsigned YW   = 6;
  localparam int unsigned CHW  = 5;
  localparam int unsigned TA   = 1;
  localparam int unsigned MAXB = 16;

  logic clk = 1'b0;
  logic arst_n_in;
  logic start, layer_done, running;
  logic in_req, in_ready, in_last, in_grant, con_valid, con_ready;
  logic out_req, out_ack;
  logic [IOW-1:0] out_data_1, out_data_2, out_data_3;
  logic [XW-1:0]  out_x_in;
  logic [YW-1:0]  out_y_in;
  logic [CHW-1:0] out_ch_in;
  logic [IOW-1:0] con_1_out, con_2_out, con_3_out;
  logic output_valid, driving_cons;
  logic [XW-1:0]  output_x;
  logic [YW-1:0]  output_y;
  logic [CHW-1:0] output_ch;

  con_bus_scheduler #(
    .IO_DATA_WIDTH     (IOW),
    .FEATURE_MAP_WIDTH (64),
    .FEATURE_MAP_HEIGHT(64),
    .OUTPUT_NB_CHANNELS(32),
    .TURNAROUND        (TA),
    .MAX_OUT_BURST     (MAXB)
  ) dut (
    .clk         (clk),
    .arst_n_in   (arst_n_in),
    .start       (start),
    .layer_done  (layer_done),
    .running     (running),
    .in_req      (in_req),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .in_grant    (in_grant),
    .con_valid   (con_valid),
    .con_ready   (con_ready),
    .out_req     (out_req),
    .out_data_1  (out_data_1),
    .out_data_2  (out_data_2),
    .out_data_3  (out_data_3),
    .out_x_in    (out_x_in),
    .out_y_in    (out_y_in),
    .out_ch_in   (out_ch_in),
    .out_ack     (out_ack),
    .con_1_out   (con_1_out),
    .con_2_out   (con_2_out),
    .con_3_out   (con_3_out),
    .output_valid(output_valid),
    .output_x    (output_x),
    .output_y    (output_y),
    .output_ch   (output_ch),
    .driving_cons(driving_cons)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  // owner: 0 = bus free, 1 = ingress owns it, 2 = egress owns it.
  // turn_left: idle cycles still to wait before the owner may transfer.
  bit             m_run      = 1'b0;
  bit             m_dir      = 1'b0;
  bit             m_last_out = 1'b1;
  int             m_owner    = 0;
  int             m_turn     = 0;
  int             m_words    = 0;
  bit             m_ov       = 1'b0;
  logic [IOW-1:0] m_d1 = '0, m_d2 = '0, m_d3 = '0;
  logic [XW-1:0]  m_x  = '0;
  logic [YW-1:0]  m_y  = '0;
  logic [CHW-1:0] m_ch = '0;

  always @(posedge clk or negedge arst_n_in) begin : model
    bit run_old, ack, go_out;
    if (!arst_n_in) begin
      m_run = 0; m_dir = 0; m_last_out = 1; m_owner = 0; m_turn = 0; m_words = 0;
      m_ov = 0; m_d1 = '0; m_d2 = '0; m_d3 = '0; m_x = '0; m_y = '0; m_ch = '0;
    end else begin
      run_old = m_run;
      ack     = (m_owner == 2) && (m_turn == 0) && out_req;
      m_ov    = ack;
      if (ack) begin
        m_d1 = out_data_1; m_d2 = out_data_2; m_d3 = out_data_3;
        m_x = out_x_in; m_y = out_y_in; m_ch = out_ch_in;
      end
      if (!run_old && start) m_run = 1;
      else if (run_old && m_owner == 0 && layer_done) m_run = 0;

      if (m_owner == 0) begin
        if (run_old && !layer_done && (in_req || out_req)) begin
          go_out  = out_req && (!in_req || !m_last_out);
          m_owner = go_out ? 2 : 1;
          m_words = 0;
          if (go_out != m_dir) begin
            m_dir  = go_out;
            m_turn = TA;
          end else begin
            m_turn = 0;
          end
        end
      end else if (m_turn > 0) begin
        m_turn--;
      end else if (m_owner == 1) begin
        if (con_valid && in_ready && in_last) begin
          m_owner = 0; m_last_out = 0;
        end
      end else begin
        if (!out_req) begin
          m_owner = 0; m_last_out = 1;
        end else begin
          m_words++;
          if (m_words == MAXB) begin
            m_owner = 0; m_last_out = 1;
          end
        end
      end
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge clk) begin : compare
    bit eg, ea;
    eg = (m_owner == 1) && (m_turn == 0);
    ea = (m_owner == 2) && (m_turn == 0) && out_req;
    chk("ctrl{run,grant,ready,ack,valid,dir}",
        128'({running, in_grant, con_ready, out_ack, output_valid, driving_cons}),
        128'({m_run, eg, eg & in_ready, ea, m_ov, m_dir}));
    chk("egress_word",
        128'({con_1_out, con_2_out, con_3_out, output_x, output_y, output_ch}),
        128'({m_d1, m_d2, m_d3, m_x, m_y, m_ch}));
  end

  // ---------------- Stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    start = 0; layer_done = 0; in_req = 0; in_ready = 0; in_last = 0; con_valid = 0;
    out_req = 0; out_data_1 = '0; out_data_2 = '0; out_data_3 = '0;
    out_x_in = '0; out_y_in = '0; out_ch_in = '0;
  endtask

  task automatic rand_word();
    out_data_1 = IOW'($urandom); out_data_2 = IOW'($urandom); out_data_3 = IOW'($urandom);
    out_x_in = XW'($urandom); out_y_in = YW'($urandom); out_ch_in = CHW'($urandom);
  endtask

  int hs, seen_dir, acks, ovs, run_len, first_run, rise, first_ack, first;
  bit tog, prev_g, prev_a;
  int order[$];
  logic [XW+YW+CHW-1:0] coord_q[$];

  initial begin
    arst_n_in = 0;
    zero_inputs();
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_running", 128'(running), 128'(0));
    chk("rst_dir", 128'(driving_cons), 128'(0));
    chk("rst_ready", 128'(con_ready), 128'(0));
    cyc();
    arst_n_in = 1;
    cyc();

    // Start with no requests.
    start = 1;
    @(negedge clk);
    chk("start_not_yet", 128'(running), 128'(0));
    cyc();
    start = 0;
    @(negedge clk);
    chk("start_running", 128'(running), 128'(1));
    repeat (4) cyc();

    // Ingress burst of 5 words, in_ready toggling.
    hs = 0; seen_dir = 0; tog = 0;
    in_req = 1;
    for (int c = 0; c < 40 && hs < 5; c++) begin
      tog = ~tog;
      in_ready = tog; con_valid = 1; in_last = (hs == 4);
      @(negedge clk);
      if (driving_cons) seen_dir = 1;
      if (con_valid && con_ready) hs++;
      cyc();
    end
    in_req = 0; con_valid = 0; in_last = 0; in_ready = 0;
    @(negedge clk);
    chk("in_handshakes", 128'(hs), 128'(5));
    chk("in_grant_fall", 128'(in_grant), 128'(0));
    chk("in_no_turn", 128'(seen_dir), 128'(0));
    repeat (3) cyc();

    // Egress of 20 words with MAX_OUT_BURST = 16.
    acks = 0; ovs = 0; run_len = 0; first_run = -1; rise = -1; first_ack = -1;
    for (int c = 0; c < 60; c++) begin
      out_req = (acks < 20);
      out_x_in = XW'(acks); out_y_in = YW'(acks * 3); out_ch_in = CHW'(acks + 7);
      out_data_1 = IOW'(acks * 101); out_data_2 = IOW'(acks + 5); out_data_3 = IOW'(~acks);
      @(negedge clk);
      if (output_valid) begin
        ovs++;
        if (coord_q.size() > 0)
          chk("eg_coords", 128'({output_x, output_y, output_ch}), 128'(coord_q.pop_front()));
        else
          chk("eg_spurious_valid", 128'(output_valid), 128'(0));
      end
      if (out_ack) begin
        coord_q.push_back({out_x_in, out_y_in, out_ch_in});
        acks++; run_len++;
        if (first_ack < 0) first_ack = c;
      end else if (run_len > 0 && first_run < 0) begin
        first_run = run_len;
      end
      if (driving_cons && rise < 0) rise = c;
      cyc();
    end
    out_req = 0;
    chk("eg_acks", 128'(acks), 128'(20));
    chk("eg_valid_pulses", 128'(ovs), 128'(20));
    chk("eg_first_burst_len", 128'(first_run), 128'(MAXB));
    chk("eg_dir_lead", 128'(first_ack - rise), 128'(1));
    repeat (3) cyc();

    // Both requesters held high: grants must alternate, ingress first.
    order.delete();
    prev_g = 0; prev_a = 0;
    in_req = 1; out_req = 1;
    for (int c = 0; c < 120; c++) begin
      con_valid = 1; in_ready = 1; in_last = ($urandom_range(0, 2) == 0);
      rand_word();
      @(negedge clk);
      if (in_grant && !prev_g) order.push_back(0);
      if (out_ack && !prev_a) order.push_back(1);
      prev_g = in_grant; prev_a = out_ack;
      cyc();
    end
    chk("order_len_ge4", 128'(order.size() >= 4), 128'(1));
    if (order.size() > 0) chk("order_first_in", 128'(order[0]), 128'(0));
    for (int i = 1; i < order.size(); i++) chk("order_alternates", 128'(order[i]), 128'(1 - order[i-1]));
    in_req = 0; out_req = 0; con_valid = 1; in_ready = 1; in_last = 1;
    repeat (10) cyc();
    zero_inputs();
    repeat (2) cyc();

    // Reset mid egress burst.
    out_req = 1;
    rand_word();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (output_valid) break;
      cyc();
      rand_word();
    end
    chk("rst_setup_valid", 128'(output_valid), 128'(1));
    #1 arst_n_in = 0;
    #1;
    chk("arst_valid", 128'(output_valid), 128'(0));
    chk("arst_ack", 128'(out_ack), 128'(0));
    chk("arst_dir", 128'(driving_cons), 128'(0));
    chk("arst_running", 128'(running), 128'(0));
    chk("arst_word", 128'({con_1_out, con_2_out, con_3_out, output_x, output_y, output_ch}),
        128'(0));
    cyc();
    out_req = 0;
    arst_n_in = 1;
    cyc();
    start = 1;
    cyc();
    start = 0;
    in_req = 1; out_req = 1;
    first = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_grant) begin first = 0; break; end
      if (out_ack) begin first = 1; break; end
      cyc();
    end
    chk("tie_after_reset", 128'(first), 128'(0));
    cyc();
    out_req = 0; in_req = 0; con_valid = 1; in_ready = 1; in_last = 1;
    cyc();
    zero_inputs();
    repeat (3) cyc();

    // layer_done during an ingress burst; start while running is ignored.
    in_req = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_grant) break;
      cyc();
    end
    chk("ld_setup_grant", 128'(in_grant), 128'(1));
    cyc();
    layer_done = 1; start = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ld_burst_running", 128'(running), 128'(1));
      cyc();
      start = 0;
    end
    con_valid = 1; in_ready = 1; in_last = 1;
    @(negedge clk);
    chk("ld_last_xfer", 128'(con_ready), 128'(1));
    cyc();
    in_req = 0; con_valid = 0; in_last = 0; in_ready = 0;
    @(negedge clk);
    chk("ld_idle_running", 128'(running), 128'(1));
    cyc();
    @(negedge clk);
    chk("ld_running_drop", 128'(running), 128'(0));
    cyc();
    layer_done = 0;
    @(negedge clk);
    chk("ld_stays_low", 128'(running), 128'(0));
    cyc();

    // Randomized traffic against the model.
    start = 1;
    cyc();
    start = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        arst_n_in = 0;
        #2 arst_n_in = 1;
      end
      start     = ($urandom_range(0, 19) == 0);
      in_req    = ($urandom_range(0, 2) != 0);
      out_req   = ($urandom_range(0, 1) != 0);
      con_valid = ($urandom_range(0, 3) != 0);
      in_ready  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 3) == 0);
      rand_word();
      cyc();
    end
    zero_inputs();
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/con_bus_scheduler.md
# con_bus_scheduler

Arbiter and sequencer for the shared `con_1`/`con_2`/`con_3` bus of `top_system`. The bus carries inbound operand words from the testbench to the load unit, and outbound result words from the output unit back to the testbench. The block grants the bus to one requester at a time and owns the bus direction (`driving_cons`). It inserts turnaround cycles on every direction change and gates all traffic with the layer-level `start`/`running` protocol.

## Interface
Parameters:
- IO_DATA_WIDTH, 16: width of each con lane.
- FEATURE_MAP_WIDTH, 64: sets X_W = $clog2(FEATURE_MAP_WIDTH).
- FEATURE_MAP_HEIGHT, 64: sets Y_W = $clog2(FEATURE_MAP_HEIGHT).
- OUTPUT_NB_CHANNELS, 32: sets CH_W = $clog2(OUTPUT_NB_CHANNELS).
- TURNAROUND, 1: idle cycles inserted after a direction change (legal range 1..7).
- MAX_OUT_BURST, 16: maximum egress words per grant (legal range ≥1).

Ports:
- clk  in  1  clock. Single clock domain; everything is rising-edge.
- arst_n_in  in  1  asynchronous, active-low reset.
- start  in  1  layer start pulse.
- layer_done  in  1  datapath has finished the layer.
- running  out  1  layer in progress.
- in_req  in  1  load unit requests an ingress burst.
- in_ready  in  1  load unit can accept a word this cycle.
- in_last  in  1  qualifies the final word of the ingress burst.
- in_grant  out  1  high for the whole ingress burst.
- con_valid  in  1  testbench has a word on the con lanes.
- con_ready  out  1  word accepted this cycle.
- out_req  in  1  output unit has a result word.
- out_data_1, out_data_2, out_data_3  in  IO_DATA_WIDTH each  result lanes.
- out_x_in  in  X_W, out_y_in  in  Y_W, out_ch_in  in  CH_W  result coordinates.
- out_ack  out  1  result word taken this cycle.
- con_1_out, con_2_out, con_3_out  out  IO_DATA_WIDTH  egress lane values.
- output_valid  out  1  egress word on the bus.
- output_x  out  X_W, output_y  out  Y_W, output_ch  out  CH_W  coordinates of the egress word.
- driving_cons  out  1  bus direction: 0 = testbench drives the lanes, 1 = DUT drives them.

## Operation
- States: IDLE, IN_BURST, OUT_BURST, TURN.
- Direction register `dir` drives `driving_cons`. Reset value 0.
- Fairness register `last_out` records whether the last burst was egress. Reset value 1, so the first tie goes to ingress.
- `running`:
  - Set on the cycle after `start` is seen while `running` is 0.
  - `start` is ignored while `running` is 1.
  - Cleared on the cycle after `layer_done` is seen in IDLE. `layer_done` is held until that happens.
- Grant decision, made in IDLE only and only while `running` is 1:
  - Only `in_req` pending: grant ingress.
  - Only `out_req` pending: grant egress.
  - Both pending: grant ingress if `last_out` = 1, otherwise egress.
  - Chosen direction equals `dir`: enter the burst state directly.
  - Chosen direction differs: go to TURN, load the turn counter with TURNAROUND, toggle `dir` on entry. Stay TURN-side for exactly TURNAROUND cycles with no transfers, then enter the burst state.
- IN_BURST:
  - `in_grant` = 1.
  - `con_ready` = `in_ready` (combinational).
  - A transfer occurs when `con_valid` & `con_ready`.
  - A transfer with `in_last` = 1 ends the burst: next state IDLE, `last_out` ← 0.
- OUT_BURST:
  - `out_ack` = `out_req` (combinational).
  - On each ack, lanes and coordinates are registered into `con_*_out`/`output_*`, and `output_valid` = 1 in the following cycle. The testbench always accepts, so there is no backpressure.
  - The burst ends when `out_req` = 0 or when the MAX_OUT_BURST-th word is acked: next state IDLE, `last_out` ← 1.
  - The burst word counter resets on each grant.
- Outside OUT_BURST, `output_valid` = 0 one cycle after the last ack.
- Outside IN_BURST, `con_ready` = 0.
- `con_*_out` and `output_*` hold their last value when `output_valid` = 0.
- `layer_done` during a burst: the burst completes normally, and `running` is dropped only once IDLE is reached.

## Timing
- Reset values: `running` 0, `in_grant` 0, `con_ready` 0, `out_ack` 0, `output_valid` 0, `driving_cons` 0, all data/coordinate outputs 0.
- Reset asserted mid-burst: state returns to IDLE asynchronously, any partial burst is dropped, no word is emitted after reset.
- Egress latency: ack in cycle N → `output_valid` and data on the bus in cycle N+1.
- Grant latency, same direction: request seen in IDLE at cycle N → burst state at N+1.
- Grant latency, direction change: burst state at N+1+TURNAROUND. `driving_cons` flips at N+1.
- Back-to-back bursts in the same direction pass through one IDLE cycle.
- Starvation bound: with both requesters held high, grants alternate in strict order.

## Test plan
- Reset then `start` with no requests → `running` = 1 at cycle 2; `driving_cons` = 0, `con_ready` = 0 throughout.
- Ingress burst of 5 words with `in_ready` toggling → exactly 5 handshakes, `in_grant` falls the cycle after the `in_last` transfer, no TURN state.
- `out_req` held for 20 words, TURNAROUND = 1, MAX_OUT_BURST = 16:
  - `driving_cons` rises 1 cycle before the first ack.
  - 16 `output_valid` pulses carry the exact coordinates.
  - Burst closes, then re-grants for the remaining 4 words.
- Both requesters high continuously → grant order IN, OUT, IN, OUT, with TURNAROUND idle cycles before each switch and no `con_ready`/`out_ack` during TURN.
- `arst_n_in` pulsed low mid egress burst → all outputs return to reset values immediately; the next grant after `start` follows the reset tie-break (ingress first).
- `layer_done` raised mid-ingress burst → `running` stays 1 until the `in_last` transfer and falls 1 cycle after IDLE; a `start` pulse while `running` = 1 has no effect.
